// File: rtl/signed_minmax_tracker.sv
// ---------------------------------------------------------------------------
// signed_minmax_tracker
//
// Purpose:
//   Consumes a stream of two's-complement samples and tracks the running
//   maximum and minimum of each frame. A frame closes after FRAME_LEN
//   samples, or earlier on flush. Each closed frame produces one result,
//   which is held on a valid/ready handshake until downstream takes it.
//
//   Signed ordering uses offset-binary keys. The sign bit is inverted, and
//   the keys are then compared as unsigned numbers. The compare is strict,
//   so a tie keeps the earlier index for both max and min.
//
// Ports:
//   clk_ip        rising-edge clock
//   rst_ip        synchronous active-high reset
//   smp_valid_ip  sample offered this cycle
//   smp_ready_op  block accepts a sample this cycle (low while a result waits)
//   smp_data_ip   signed sample
//   flush_ip      close the frame in progress early
//   res_valid_op  frame result is held on the result outputs
//   res_ready_ip  downstream takes the result
//   max_op        frame maximum (signed)
//   min_op        frame minimum (signed)
//   max_idx_op    index of first occurrence of the maximum
//   min_idx_op    index of first occurrence of the minimum
//   count_op      number of samples in the frame
//   all_eq_op     every sample in the frame had the same value
// ---------------------------------------------------------------------------
module signed_minmax_tracker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk_ip,
    input  logic              rst_ip,
    input  logic              smp_valid_ip,
    output logic              smp_ready_op,
    input  logic [DATA_W-1:0] smp_data_ip,
    input  logic              flush_ip,
    output logic              res_valid_op,
    input  logic              res_ready_ip,
    output logic [DATA_W-1:0] max_op,
    output logic [DATA_W-1:0] min_op,
    output logic [IDX_W-1:0]  max_idx_op,
    output logic [IDX_W-1:0]  min_idx_op,
    output logic [IDX_W:0]    count_op,
    output logic              all_eq_op
);

    // S_FIRST waits for the opening sample of a frame. S_ACC folds in the
    // later samples. S_OUT holds the finished result.
    localparam logic [1:0] S_FIRST = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic [IDX_W:0] FRAME_LEN_C = (IDX_W+1)'(FRAME_LEN);
    localparam logic [IDX_W:0] ONE_C       = (IDX_W+1)'(1);

    logic [1:0]        state;
    logic              accept;
    logic              sample_gt_max;
    logic              sample_lt_min;
    logic [IDX_W:0]    next_count;
    logic              close_frame;

    // Invert the sign bit so that an unsigned compare of the keys orders
    // the original values as signed numbers.
    function automatic logic [DATA_W-1:0] to_key(input logic [DATA_W-1:0] v);
        return {~v[DATA_W-1], v[DATA_W-2:0]};
    endfunction

    assign smp_ready_op = (state != S_OUT);
    assign res_valid_op = (state == S_OUT);
    assign accept       = smp_valid_ip & smp_ready_op;

    // Strict compares. An equal sample never displaces the stored
    // extremum, so the first occurrence keeps its index.
    assign sample_gt_max = to_key(smp_data_ip) > to_key(max_op);
    assign sample_lt_min = to_key(smp_data_ip) < to_key(min_op);

    assign next_count = count_op + ONE_C;

    // A frame can close only once it has at least one sample (S_ACC).
    // A sample accepted in the same cycle as flush is counted before the
    // frame closes. The count cannot pass FRAME_LEN because reaching
    // FRAME_LEN forces the close.
    assign close_frame = (state == S_ACC) &&
                         (flush_ip || (accept && (next_count == FRAME_LEN_C)));

    // Frame state and result registers. The result registers double as
    // the running accumulators. They are frozen while a result is held, and
    // they keep their last values after hand-off until a new frame starts.
    always_ff @(posedge clk_ip) begin
        if (rst_ip) begin
            state      <= S_FIRST;
            max_op     <= '0;
            min_op     <= '0;
            max_idx_op <= '0;
            min_idx_op <= '0;
            count_op   <= '0;
            all_eq_op  <= 1'b0;
        end else begin
            case (state)
                S_FIRST: begin
                    if (accept) begin
                        max_op     <= smp_data_ip;
                        min_op     <= smp_data_ip;
                        max_idx_op <= '0;
                        min_idx_op <= '0;
                        count_op   <= ONE_C;
                        all_eq_op  <= 1'b1;
                        state      <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        if (sample_gt_max) begin
                            max_op     <= smp_data_ip;
                            max_idx_op <= count_op[IDX_W-1:0];
                        end
                        if (sample_lt_min) begin
                            min_op     <= smp_data_ip;
                            min_idx_op <= count_op[IDX_W-1:0];
                        end
                        if (smp_data_ip != max_op) begin
                            all_eq_op <= 1'b0;
                        end
                        count_op <= next_count;
                    end
                    if (close_frame) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (res_ready_ip) begin
                        state <= S_FIRST;
                    end
                end
                default: begin
                    state <= S_FIRST;
                end
            endcase
        end
    end

endmodule

// File: doc/signed_minmax_tracker.md
Name: signed_minmax_tracker

Overview:
Streaming consumer of signed 8-bit samples. Tracks running maximum and minimum over a frame using the same offset-binary signed-compare rule as the 8-bit comparator (MSB inverted, then unsigned compare, cascade-style greater/equal/less). Emits one result per frame (max, min, their indices, sample count, all-equal flag) over a valid/ready handshake. Sits directly downstream of sample capture and replaces ad-hoc per-sample comparator chaining.

Parameters:
DATA_W, 8, sample width (two's complement)
FRAME_LEN, 16, samples per frame before automatic close (>=2)
IDX_W, $clog2(FRAME_LEN), index width

Ports:
clk_ip  input  1  clock, all logic rising-edge
rst_ip  input  1  synchronous reset, active-high
smp_valid_ip  input  1  sample offered
smp_ready_op  output  1  block accepts sample this cycle
smp_data_ip  input  DATA_W  signed sample
flush_ip  input  1  close current frame early
res_valid_op  output  1  frame result held
res_ready_ip  input  1  downstream takes result
max_op  output  DATA_W  frame maximum (signed)
min_op  output  DATA_W  frame minimum (signed)
max_idx_op  output  IDX_W  index of first occurrence of max
min_idx_op  output  IDX_W  index of first occurrence of min
count_op  output  IDX_W+1  samples in frame
all_eq_op  output  1  every sample in frame equal

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_ip, rst_ip).
- Reset (rst_ip high at edge): state S_FIRST; res_valid_op=0; max_op=min_op=0; max_idx_op=min_idx_op=0; count_op=0; all_eq_op=0. Reset wins over every other input, including mid-frame and mid-handshake; partial frame discarded, no result emitted.
- Accept = smp_valid_ip & smp_ready_op. smp_ready_op = (state != S_OUT), so 1 from the cycle after reset.
- Compare: keys ka = {~a[MSB], a[MSB-1:0]}, kb likewise, unsigned compare. Greater-than is strict, so ties keep the earlier index for both max and min.
- S_FIRST: on accept, max=min=sample, both idx=0, count=1, all_eq=1 -> S_ACC. flush_ip ignored (no empty frames).
- S_ACC: on accept at index i=count: replace max if sample > max; replace min if sample < min; clear all_eq if sample != max; count+1.
- Close when the accepted sample makes count==FRAME_LEN, or when flush_ip=1 (with or without a same-cycle accept; a same-cycle sample is included before close). Next state S_OUT; res_valid_op=1 the cycle after the closing edge (1-cycle latency).
- S_OUT: outputs frozen; smp_ready_op=0. On res_valid_op & res_ready_ip: res_valid_op=0 -> S_FIRST; the next sample is accepted from the following cycle. flush_ip ignored.
- Result registers hold last values after hand-off until the next frame's first sample overwrites them.
- Width: count_op saturates at FRAME_LEN by construction; indices wrap never (close precedes overflow).

Test Plan:
- FRAME_LEN=4, samples 0x05,0xFB,0x7F,0x80 back-to-back, res_ready_ip=1 -> res_valid 1 cycle after 4th accept; max=0x7F idx=2, min=0x80 idx=3, count=4, all_eq=0; back to S_FIRST next cycle.
- Ties: 0x10 x4 -> max=min=0x10, both idx=0, all_eq=1; then 0xFF,0x00,0xFF,0x00 -> max=0x00 idx=1, min=0xFF idx=0.
- Flush: samples 0x03,0xFD, flush_ip with 3rd sample 0x00 -> count=3, max=0x03 idx0, min=0xFD idx1; flush alone in S_FIRST -> no result.
- Backpressure: hold res_ready_ip=0 for 5 cycles after close while smp_valid_ip=1 -> smp_ready_op=0, all result outputs stable, no sample lost; first sample accepted the cycle after hand-off.
- Reset mid-frame after 2 samples and again while res_valid_op=1 -> all outputs reset values next cycle, next frame starts idx 0.
- Random signed streams (1000 frames, random valid/ready/flush) against scoreboard model using $signed compare.
